// File: rtl/beat_tone_player_if.sv
`default_nettype none
// ============================================================================
// Module  : beat_tone_player_if
// Brief   : Beat-index request lines and speaker/status returns of the player.
// Revision: 1.0
// ============================================================================
interface beat_tone_player_if;
  logic       en;
  logic       beat_tick;
  logic [7:0] ibeat;
  logic       audio_out;
  logic       note_act;
  logic [3:0] cur_note;
  logic       idx_err;

  modport master (
    output en, beat_tick, ibeat,
    input  audio_out, note_act, cur_note, idx_err
  );

  modport slave (
    input  en, beat_tick, ibeat,
    output audio_out, note_act, cur_note, idx_err
  );
endinterface
`default_nettype wire

// File: rtl/beat_tone_player.sv
`default_nettype none
// ============================================================================
// Module  : beat_tone_player
// Brief   : Looks each beat index up in a score ROM and plays a square-wave
//           tone for a fixed duration, then stays silent until the next beat.
// Revision: 1.0
// ============================================================================
module beat_tone_player #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int NOTE_CYCLES = 22_500_000,
  parameter int DIV_W       = 20,
  parameter int SCORE_LEN   = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  beat_tone_player_if.slave bus
);

  localparam int DUR_W = $clog2(NOTE_CYCLES + 1);
  localparam logic [DUR_W-1:0] C_DUR_LAST = DUR_W'(NOTE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  function automatic logic [DIV_W-1:0] f_half_period(input logic [3:0] n);
    case (n)
      4'd1:    f_half_period = DIV_W'(CLK_HZ / (2 * 262));
      4'd2:    f_half_period = DIV_W'(CLK_HZ / (2 * 277));
      4'd3:    f_half_period = DIV_W'(CLK_HZ / (2 * 294));
      4'd4:    f_half_period = DIV_W'(CLK_HZ / (2 * 311));
      4'd5:    f_half_period = DIV_W'(CLK_HZ / (2 * 330));
      4'd6:    f_half_period = DIV_W'(CLK_HZ / (2 * 349));
      4'd7:    f_half_period = DIV_W'(CLK_HZ / (2 * 370));
      4'd8:    f_half_period = DIV_W'(CLK_HZ / (2 * 392));
      4'd9:    f_half_period = DIV_W'(CLK_HZ / (2 * 415));
      4'd10:   f_half_period = DIV_W'(CLK_HZ / (2 * 440));
      4'd11:   f_half_period = DIV_W'(CLK_HZ / (2 * 466));
      4'd12:   f_half_period = DIV_W'(CLK_HZ / (2 * 494));
      default: f_half_period = DIV_W'(1);
    endcase
  endfunction

  function automatic logic [3:0] f_score(input logic [7:0] idx);
    case (idx)
      8'd0:    f_score = 4'd1;
      8'd1:    f_score = 4'd3;
      8'd2:    f_score = 4'd5;
      8'd3:    f_score = 4'd6;
      8'd4:    f_score = 4'd8;
      8'd5:    f_score = 4'd10;
      8'd6:    f_score = 4'd12;
      default: f_score = 4'd0;
    endcase
  endfunction

  state_t           r_state;
  logic [7:0]       r_beat;
  logic [DIV_W-1:0] r_hp;
  logic [DIV_W-1:0] r_div;
  logic [DUR_W-1:0] r_dur;
  logic             r_audible;
  logic             r_audio;
  logic             r_note_act;
  logic [3:0]       r_cur_note;
  logic             r_idx_err;

  logic             w_in_range;
  logic [3:0]       w_note;
  logic             w_audible;

  assign w_in_range = (int'(r_beat) < SCORE_LEN);
  assign w_note     = w_in_range ? f_score(r_beat) : 4'd0;
  // Codes 13..15 are rests as well as 0.
  assign w_audible  = (w_note != 4'd0) && (w_note <= 4'd12);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat     <= 8'd0;
      r_hp       <= '0;
      r_div      <= '0;
      r_dur      <= '0;
      r_audible  <= 1'b0;
      r_audio    <= 1'b0;
      r_note_act <= 1'b0;
      r_cur_note <= 4'd0;
      r_idx_err  <= 1'b0;
    end else if (!bus.en) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_dur      <= '0;
      r_audio    <= 1'b0;
      r_note_act <= 1'b0;
      r_cur_note <= 4'd0;
      r_idx_err  <= 1'b0;
    end else if (bus.beat_tick) begin
      // Any beat, even a repeat of the current index, restarts the note phase.
      r_state    <= S_LOAD;
      r_beat     <= bus.ibeat;
      r_audio    <= 1'b0;
      r_note_act <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_cur_note <= w_note;
          r_idx_err  <= ~w_in_range;
          r_hp       <= f_half_period(w_note);
          r_audible  <= w_audible;
          r_note_act <= w_audible;
          r_div      <= '0;
          r_dur      <= '0;
          r_audio    <= 1'b0;
          r_state    <= S_PLAY;
        end
        S_PLAY: begin
          if (r_dur == C_DUR_LAST) begin
            r_audio    <= 1'b0;
            r_note_act <= 1'b0;
            r_state    <= S_GAP;
          end else begin
            r_dur <= r_dur + DUR_W'(1);
            if (r_div == r_hp - DIV_W'(1)) begin
              r_div   <= '0;
              r_audio <= r_audio ^ r_audible;
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
        end
        S_IDLE, S_GAP: begin
          r_audio    <= 1'b0;
          r_note_act <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.audio_out = r_audio;
  assign bus.note_act  = r_note_act;
  assign bus.cur_note  = r_cur_note;
  assign bus.idx_err   = r_idx_err;

endmodule
`default_nettype wire

// File: tb/tb_beat_tone_player.sv
`default_nettype none
// ============================================================================
// Module  : tb_beat_tone_player
// Brief   : Self-checking bench for beat_tone_player against a timeline model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_beat_tone_player;

  localparam int CLK_HZ = 1_000_000;
  localparam int NOTE   = 10_000;
  localparam int FREQ [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};
  localparam int SCORE [8] = '{1, 3, 5, 6, 8, 10, 12, 0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  beat_tone_player_if bus ();

  beat_tone_player #(
    .CLK_HZ     (CLK_HZ),
    .NOTE_CYCLES(NOTE),
    .DIV_W      (20),
    .SCORE_LEN  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int trace_mis = 0;
  int first_mis_cyc = 0;
  logic [6:0] first_obs, first_exp;

  // Model: time of last accepted beat plus the note/error it selected.
  bit m_active = 1'b0;
  int m_T = -100;
  int m_note = 0, m_err = 0, m_old_note = 0, m_old_err = 0;

  function automatic int score(input int idx);
    return (idx >= 0 && idx < 8) ? SCORE[idx] : 0;
  endfunction

  function automatic int hp_of(input int n);
    return (n >= 1 && n <= 12) ? CLK_HZ / (2 * FREQ[n-1]) : 0;
  endfunction

  task automatic model_expect(output logic [6:0] e);
    int k;
    logic a, na, ie;
    logic [3:0] cn;
    a = 1'b0; na = 1'b0; cn = 4'd0; ie = 1'b0;
    if (m_active) begin
      if (cyc == m_T + 1) begin
        cn = 4'(m_old_note);
        ie = m_old_err[0];
      end else begin
        k  = cyc - m_T - 2;
        cn = 4'(m_note);
        ie = m_err[0];
        if (k < NOTE && hp_of(m_note) > 0) begin
          na = 1'b1;
          a  = ((k / hp_of(m_note)) % 2) == 1;
        end
      end
    end
    e = {a, na, cn, ie};
  endtask

  // One cycle: compare the trace, apply inputs, advance the model at the edge.
  task automatic step(input logic en, input logic tk, input logic [7:0] ib, input logic rs);
    logic [6:0] e, o;
    model_expect(e);
    o = {bus.audio_out, bus.note_act, bus.cur_note, bus.idx_err};
    if (o !== e) begin
      if (trace_mis == 0) begin
        first_mis_cyc = cyc; first_obs = o; first_exp = e;
      end
      trace_mis++;
    end
    bus.en = en; bus.beat_tick = tk; bus.ibeat = ib; reset = rs;
    @(posedge clk);
    if (rs || !en) begin
      m_active = 1'b0; m_note = 0; m_err = 0;
    end else if (tk) begin
      if (!m_active) begin
        m_old_note = 0; m_old_err = 0;
      end else if (cyc != m_T + 1) begin
        m_old_note = m_note; m_old_err = m_err;
      end
      m_T = cyc; m_note = score(int'(ib)); m_err = (ib >= 8) ? 1 : 0; m_active = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) step(1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic trace_check(input string name);
    checks++;
    if (trace_mis !== 0) begin
      errors++;
      $display("FAIL %s_trace: %0d cycle mismatches, first at cycle %0d got %b expected %b",
               name, trace_mis, first_mis_cyc, first_obs, first_exp);
    end
    trace_mis = 0;
  endtask

  task automatic test_reset();
    trace_mis = 0;
    step(1'b1, 1'b0, 8'd0, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (bus.audio_out !== 1'b0) begin errors++; $display("FAIL reset_audio: got %b expected 0", bus.audio_out); end
    checks++; if (bus.note_act !== 1'b0) begin errors++; $display("FAIL reset_note_act: got %b expected 0", bus.note_act); end
    checks++; if (bus.cur_note !== 4'd0) begin errors++; $display("FAIL reset_cur_note: got %0d expected 0", bus.cur_note); end
    checks++; if (bus.idx_err !== 1'b0) begin errors++; $display("FAIL reset_idx_err: got %b expected 0", bus.idx_err); end
    trace_check("reset");
  endtask

  task automatic test_note_a4();
    int t;
    int hp = 1136;
    t = cyc;
    step(1'b1, 1'b1, 8'd5, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (bus.cur_note !== 4'd10) begin errors++; $display("FAIL a4_cur_note: got %0d expected 10", bus.cur_note); end
    checks++; if (bus.note_act !== 1'b1) begin errors++; $display("FAIL a4_note_act: got %b expected 1", bus.note_act); end
    run_until(t + hp + 1);
    checks++; if (bus.audio_out !== 1'b0) begin errors++; $display("FAIL a4_before_rise: got %b expected 0", bus.audio_out); end
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (bus.audio_out !== 1'b1) begin errors++; $display("FAIL a4_first_rise: got %b expected 1", bus.audio_out); end
    run_until(t + 2 + 3 * hp - 1);
    checks++; if (bus.audio_out !== 1'b0) begin errors++; $display("FAIL a4_period_low: got %b expected 0", bus.audio_out); end
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (bus.audio_out !== 1'b1) begin errors++; $display("FAIL a4_period_rise: got %b expected 1", bus.audio_out); end
    run_until(t + NOTE + 1);
    checks++; if (bus.note_act !== 1'b1) begin errors++; $display("FAIL a4_last_play: got %b expected 1", bus.note_act); end
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++;
    if ({bus.audio_out, bus.note_act, bus.cur_note} !== {1'b0, 1'b0, 4'd10}) begin
      errors++;
      $display("FAIL a4_gap: got %b expected %b", {bus.audio_out, bus.note_act, bus.cur_note}, 6'b001010);
    end
    trace_check("a4");
  endtask

  task automatic test_rest();
    int hi = 0;
    step(1'b1, 1'b1, 8'd7, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (bus.cur_note !== 4'd0) begin errors++; $display("FAIL rest_cur_note: got %0d expected 0", bus.cur_note); end
    checks++; if (bus.note_act !== 1'b0) begin errors++; $display("FAIL rest_note_act: got %b expected 0", bus.note_act); end
    for (int i = 0; i < NOTE; i++) begin
      if (bus.audio_out === 1'b1) hi++;
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL rest_silent: got %0d high cycles expected 0", hi); end
    trace_check("rest");
  endtask

  task automatic test_idx_err();
    int t, t2;
    t = cyc;
    step(1'b1, 1'b1, 8'd9, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (bus.idx_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus.idx_err); end
    checks++; if ({bus.note_act, bus.cur_note} !== 5'd0) begin errors++; $display("FAIL err_silent: got %b expected 0", {bus.note_act, bus.cur_note}); end
    run_until(t + 3000);
    t2 = cyc;
    step(1'b1, 1'b1, 8'd0, 1'b0);
    checks++; if (bus.idx_err !== 1'b1) begin errors++; $display("FAIL err_hold_load: got %b expected 1", bus.idx_err); end
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if ({bus.idx_err, bus.cur_note} !== 5'd1) begin errors++; $display("FAIL err_clear: got %b expected 00001", {bus.idx_err, bus.cur_note}); end
    run_until(t2 + 1909);
    checks++; if (bus.audio_out !== 1'b0) begin errors++; $display("FAIL c4_before_rise: got %b expected 0", bus.audio_out); end
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (bus.audio_out !== 1'b1) begin errors++; $display("FAIL c4_first_rise: got %b expected 1", bus.audio_out); end
    trace_check("idx_err");
  endtask

  task automatic test_retrigger();
    int t, t2, d;
    t = cyc;
    step(1'b1, 1'b1, 8'd0, 1'b0);
    d = int'($urandom_range(2000, 3700));
    run_until(t + d);
    checks++; if (bus.audio_out !== 1'b1) begin errors++; $display("FAIL retrig_pre_high: got %b expected 1", bus.audio_out); end
    t2 = cyc;
    step(1'b1, 1'b1, 8'd6, 1'b0);
    checks++;
    if ({bus.audio_out, bus.note_act, bus.cur_note} !== {1'b0, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL retrig_load: got %b expected 000001", {bus.audio_out, bus.note_act, bus.cur_note});
    end
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if ({bus.note_act, bus.cur_note} !== {1'b1, 4'd12}) begin errors++; $display("FAIL retrig_note: got %b expected 11100", {bus.note_act, bus.cur_note}); end
    run_until(t2 + 1013);
    checks++; if (bus.audio_out !== 1'b0) begin errors++; $display("FAIL b4_before_rise: got %b expected 0", bus.audio_out); end
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if (bus.audio_out !== 1'b1) begin errors++; $display("FAIL b4_first_rise: got %b expected 1", bus.audio_out); end
    trace_check("retrig");
  endtask

  task automatic test_enable_reset();
    run_until(cyc + int'($urandom_range(100, 800)));
    step(1'b0, 1'b0, 8'd0, 1'b0);
    checks++; if ({bus.audio_out, bus.note_act, bus.cur_note, bus.idx_err} !== 7'd0) begin errors++; $display("FAIL en_off: got %b expected 0", {bus.audio_out, bus.note_act, bus.cur_note, bus.idx_err}); end
    step(1'b1, 1'b1, 8'd2, 1'b0);
    run_until(cyc + int'($urandom_range(300, 1500)));
    step(1'b0, 1'b1, 8'd3, 1'b0);
    checks++; if ({bus.audio_out, bus.note_act, bus.cur_note, bus.idx_err} !== 7'd0) begin errors++; $display("FAIL en_beats_tick: got %b expected 0", {bus.audio_out, bus.note_act, bus.cur_note, bus.idx_err}); end
    step(1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    checks++; if ({bus.note_act, bus.cur_note} !== 5'd0) begin errors++; $display("FAIL en_stay_idle: got %b expected 0", {bus.note_act, bus.cur_note}); end
    step(1'b1, 1'b1, 8'd4, 1'b0);
    run_until(cyc + int'($urandom_range(200, 900)));
    step(1'b1, 1'b0, 8'd0, 1'b1);
    checks++; if ({bus.audio_out, bus.note_act, bus.cur_note, bus.idx_err} !== 7'd0) begin errors++; $display("FAIL mid_reset: got %b expected 0", {bus.audio_out, bus.note_act, bus.cur_note, bus.idx_err}); end
    trace_check("enable");
  endtask

  task automatic test_random_beats();
    int ib, gap;
    for (int n = 0; n < 4; n++) begin
      ib = int'($urandom_range(0, 11));
      step(1'b1, 1'b1, 8'(ib), 1'b0);
      gap = int'($urandom_range(50, 8000));
      repeat (gap) step(1'b1, 1'b0, 8'($urandom), 1'b0);
      checks++;
      if (bus.cur_note !== 4'(score(ib))) begin
        errors++;
        $display("FAIL rand_cur_note: ibeat %0d got %0d expected %0d", ib, bus.cur_note, score(ib));
      end
    end
    trace_check("random");
  endtask

  initial begin
    reset = 1'b1;
    bus.en = 1'b1;
    bus.beat_tick = 1'b0;
    bus.ibeat = 8'd0;
    @(posedge clk);
    #1;
    cyc = 1;
    test_reset();
    test_note_a4();
    test_rest();
    test_idx_err();
    test_retrigger();
    test_enable_reset();
    step(1'b1, 1'b0, 8'd0, 1'b0);
    test_random_beats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
